// File: rtl/apb_mem_slave.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// apb_mem_slave
//   APB slave that fronts a word-addressed memory of DEPTH words, each
//   DATA_WIDTH bits wide. Every access has a setup phase followed by an access
//   phase. The access phase can be stretched by WAIT_STATES cycles with pready
//   held low. Writes honour per-byte strobes. Addresses at or beyond DEPTH get
//   an error response and never touch memory. On reset, every word is
//   initialised to its own index.
//
// Parameters
//   ADDR_WIDTH  width of paddr (a word index; there is no byte shift)
//   DATA_WIDTH  width of pwdata/prdata; must be 8, 16, 32 or 64
//   DEPTH       number of words; must not exceed 2**ADDR_WIDTH
//   WAIT_STATES number of pready-low access cycles per transfer, 0..15
//
// Ports
//   pclk     in   clock; all state changes on its rising edge
//   prst     in   asynchronous active-low reset
//   psel     in   slave select
//   penable  in   access-phase indicator
//   pwrite   in   1 = write, 0 = read
//   paddr    in   word index
//   pwdata   in   write data, sampled at the completion edge
//   pstrb    in   byte-lane write enables, sampled at the completion edge
//   prdata   out  registered read data; 0 outside read access phases
//   pready   out  registered transfer-complete indicator
//   pslverr  out  registered error response, held for the whole access phase
// ----------------------------------------------------------------------------
module apb_mem_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                    pclk,
    input  logic                    prst,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // DEPTH is widened by one bit, so the range compare is exact even when
    // DEPTH == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [3:0]          WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Byte-lane merge: the lanes whose strobe bit is set take the new data.
    // All other lanes keep the old word.
    function automatic logic [DATA_WIDTH-1:0] lane_merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                merged[b*8 +: 8] = new_word[b*8 +: 8];
            end else begin
                merged[b*8 +: 8] = old_word[b*8 +: 8];
            end
        end
        return merged;
    endfunction

    state_t                  state_r;
    logic [3:0]              cnt_r;
    logic [IDX_W-1:0]        addr_idx_r;
    logic                    write_r;
    logic [DATA_WIDTH-1:0]   prdata_r;
    logic                    pready_r;
    logic                    pslverr_r;
    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

    logic [IDX_W-1:0]        paddr_idx_s;
    logic                    in_range_s;
    logic                    setup_s;
    logic                    complete_s;
    logic                    wr_en_s;
    logic [DATA_WIDTH-1:0]   rd_word_s;

    assign paddr_idx_s = paddr[IDX_W-1:0];
    assign in_range_s  = ({1'b0, paddr} < DEPTH_EXT);
    assign rd_word_s   = mem_r[paddr_idx_s];

    // Setup phase is recognised only in IDLE. psel with penable in IDLE is
    // not a legal start, so it is ignored.
    assign setup_s    = (state_r == ST_IDLE) && psel && !penable;
    assign complete_s = (state_r == ST_ACCESS) && psel && penable && (cnt_r == 4'd0);

    // pslverr_r was latched at setup, so it also marks a write as out of range.
    assign wr_en_s    = complete_s && write_r && !pslverr_r;

    assign prdata  = prdata_r;
    assign pready  = pready_r;
    assign pslverr = pslverr_r;

    // Transfer FSM: tracks the phase, counts wait states and drives the
    // registered response outputs.
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            addr_idx_r <= '0;
            write_r    <= 1'b0;
            prdata_r   <= '0;
            pready_r   <= 1'b1;
            pslverr_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (setup_s) begin
                        state_r    <= ST_ACCESS;
                        cnt_r      <= WAIT_INIT;
                        addr_idx_r <= paddr_idx_s;
                        write_r    <= pwrite;
                        // pready is kept as a register that mirrors the
                        // "IDLE or counter==0" decode of the next state.
                        pready_r   <= (WAIT_INIT == 4'd0);
                        if (!in_range_s) begin
                            pslverr_r <= 1'b1;
                            prdata_r  <= '0;
                        end else if (!pwrite) begin
                            pslverr_r <= 1'b0;
                            prdata_r  <= rd_word_s;
                        end else begin
                            pslverr_r <= 1'b0;
                            prdata_r  <= '0;
                        end
                    end else begin
                        state_r  <= ST_IDLE;
                        pready_r <= 1'b1;
                    end
                end

                ST_ACCESS: begin
                    if (!psel) begin
                        // Abort: the master dropped psel, so nothing is
                        // committed.
                        state_r   <= ST_IDLE;
                        cnt_r     <= 4'd0;
                        prdata_r  <= '0;
                        pslverr_r <= 1'b0;
                        pready_r  <= 1'b1;
                    end else if (penable) begin
                        if (cnt_r != 4'd0) begin
                            cnt_r    <= cnt_r - 4'd1;
                            pready_r <= (cnt_r == 4'd1);
                        end else begin
                            state_r   <= ST_IDLE;
                            prdata_r  <= '0;
                            pslverr_r <= 1'b0;
                            pready_r  <= 1'b1;
                        end
                    end else begin
                        // Selected without penable while in ACCESS: hold
                        // everything until the master continues or aborts.
                        state_r <= ST_ACCESS;
                    end
                end

                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= 4'd0;
                    prdata_r  <= '0;
                    pslverr_r <= 1'b0;
                    pready_r  <= 1'b1;
                end
            endcase
        end
    end

    // Memory array: on reset, each word is set to its own index. A write
    // commits only at an in-range completion edge.
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= DATA_WIDTH'(i);
            end
        end else if (wr_en_s) begin
            mem_r[addr_idx_r] <= lane_merge(mem_r[addr_idx_r], pwdata, pstrb);
        end
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
`timescale 1ns/1ps
// Directed testbench for apb_mem_slave.
// It uses three instances with WAIT_STATES = 0, 2 and 3, which share every
// input except psel. Index 0 -> WS0, 1 -> WS2, 2 -> WS3.
module tb_apb_mem_slave;

    logic        pclk;
    logic        prst;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        sel    [3];
    logic        rdy    [3];
    logic        slverr [3];
    logic [31:0] rdata  [3];

    int checks   = 0;
    int failures = 0;

    // Results of the most recent transfer.
    logic [31:0] r_rd;
    logic        r_err;
    logic        r_errf;
    int          r_waits;
    logic        r_stable;
    logic        r_to;
    logic [31:0] r_post;
    logic        r_prdy;
    logic        r_perr;

    apb_mem_slave #(.WAIT_STATES(0)) u_ws0 (
        .pclk(pclk), .prst(prst), .psel(sel[0]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(rdata[0]), .pready(rdy[0]), .pslverr(slverr[0])
    );
    apb_mem_slave #(.WAIT_STATES(2)) u_ws2 (
        .pclk(pclk), .prst(prst), .psel(sel[1]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(rdata[1]), .pready(rdy[1]), .pslverr(slverr[1])
    );
    apb_mem_slave #(.WAIT_STATES(3)) u_ws3 (
        .pclk(pclk), .prst(prst), .psel(sel[2]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(rdata[2]), .pready(rdy[2]), .pslverr(slverr[2])
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Runs one complete APB transfer. Call it just after a falling edge. It
    // returns just after a later falling edge with the bus idle, so a call
    // placed directly after it gives a back-to-back transfer.
    task automatic xfer(input int w, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] first;
        sel[w] = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = addr; pwdata = data; pstrb = strb;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        first = rdata[w]; r_errf = slverr[w];
        r_waits = 0; r_stable = 1'b1; r_to = 1'b0;
        while (rdy[w] !== 1'b1 && !r_to) begin
            @(negedge pclk); #1;
            if (rdata[w] !== first || slverr[w] !== r_errf) r_stable = 1'b0;
            r_waits++;
            if (r_waits > 20) r_to = 1'b1;
        end
        r_rd = rdata[w]; r_err = slverr[w];
        @(negedge pclk);
        sel[w] = 1'b0; penable = 1'b0;
        #1;
        r_post = rdata[w]; r_prdy = rdy[w]; r_perr = slverr[w];
        checks++;
        if (r_to !== 1'b0) begin
            failures++;
            $display("FAIL xfer_timeout inst=%0d addr=%h: pready never rose", w, addr);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rdy[i] !== 1'b1) begin failures++; $display("FAIL reset_pready inst=%0d got=%b exp=1", i, rdy[i]); end
            checks++;
            if (rdata[i] !== 32'h0) begin failures++; $display("FAIL reset_prdata inst=%0d got=%h exp=0", i, rdata[i]); end
            checks++;
            if (slverr[i] !== 1'b0) begin failures++; $display("FAIL reset_pslverr inst=%0d got=%b exp=0", i, slverr[i]); end
        end
    endtask

    task automatic test_read_default();
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0);
        checks++;
        if (r_rd !== 32'h0000_0010) begin failures++; $display("FAIL read_0x10 got=%h exp=00000010", r_rd); end
        checks++;
        if (r_waits !== 0) begin failures++; $display("FAIL read_latency got=%0d exp=0", r_waits); end
        checks++;
        if (r_err !== 1'b0) begin failures++; $display("FAIL read_pslverr got=%b exp=0", r_err); end
        checks++;
        if (r_post !== 32'h0 || r_prdy !== 1'b1) begin
            failures++; $display("FAIL read_after got prdata=%h pready=%b exp 0/1", r_post, r_prdy);
        end
    endtask

    task automatic test_strobe_write();
        xfer(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 4'b0101);
        checks++;
        if (r_err !== 1'b0 || r_rd !== 32'h0) begin
            failures++; $display("FAIL strb_write_resp got err=%b prdata=%h exp 0/0", r_err, r_rd);
        end
        xfer(0, 1'b0, 32'd5, 32'h0, 4'h0);
        checks++;
        if (r_rd !== 32'h00AD_00EF) begin failures++; $display("FAIL strb_readback got=%h exp=00AD00EF", r_rd); end
    endtask

    task automatic test_wait_states();
        xfer(1, 1'b0, 32'h21, 32'h0, 4'h0);
        checks++;
        if (r_waits !== 2) begin failures++; $display("FAIL ws2_read_waits got=%0d exp=2", r_waits); end
        checks++;
        if (r_stable !== 1'b1 || r_rd !== 32'h21) begin
            failures++; $display("FAIL ws2_read_data got=%h stable=%b exp 00000021/1", r_rd, r_stable);
        end
        xfer(1, 1'b1, 32'h21, 32'hCAFE_F00D, 4'hF);
        checks++;
        if (r_waits !== 2) begin failures++; $display("FAIL ws2_write_waits got=%0d exp=2", r_waits); end
        xfer(1, 1'b0, 32'h21, 32'h0, 4'h0);
        checks++;
        if (r_rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL ws2_readback got=%h exp=CAFEF00D", r_rd); end
    endtask

    task automatic test_out_of_range();
        xfer(0, 1'b1, 32'd300, 32'h1234_5678, 4'hF);
        checks++;
        if (r_errf !== 1'b1 || r_err !== 1'b1) begin
            failures++; $display("FAIL oor_write_err got first=%b last=%b exp 1/1", r_errf, r_err);
        end
        checks++;
        if (r_perr !== 1'b0) begin failures++; $display("FAIL oor_err_clear got=%b exp=0", r_perr); end
        xfer(0, 1'b0, 32'd44, 32'h0, 4'h0);
        checks++;
        if (r_rd !== 32'h0000_002C || r_err !== 1'b0) begin
            failures++; $display("FAIL oor_alias_read got=%h err=%b exp 0000002C/0", r_rd, r_err);
        end
        xfer(0, 1'b0, 32'd255, 32'h0, 4'h0);
        checks++;
        if (r_rd !== 32'hFF || r_err !== 1'b0) begin
            failures++; $display("FAIL last_word_read got=%h err=%b exp 000000FF/0", r_rd, r_err);
        end
        xfer(0, 1'b0, 32'd256, 32'h0, 4'h0);
        checks++;
        if (r_rd !== 32'h0 || r_err !== 1'b1) begin
            failures++; $display("FAIL depth_read got=%h err=%b exp 00000000/1", r_rd, r_err);
        end
        xfer(1, 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF);
        checks++;
        if (r_errf !== 1'b1 || r_stable !== 1'b1 || r_waits !== 2) begin
            failures++; $display("FAIL ws2_oor_err got err=%b stable=%b waits=%0d exp 1/1/2", r_errf, r_stable, r_waits);
        end
    endtask

    task automatic test_abort();
        sel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'd7; pwdata = 32'hAAAA_5555; pstrb = 4'hF;
        @(negedge pclk);
        sel[0] = 1'b0;
        @(negedge pclk); #1;
        checks++;
        if (rdata[0] !== 32'h0 || slverr[0] !== 1'b0 || rdy[0] !== 1'b1) begin
            failures++; $display("FAIL abort_state got prdata=%h err=%b rdy=%b exp 0/0/1", rdata[0], slverr[0], rdy[0]);
        end
        xfer(0, 1'b0, 32'd7, 32'h0, 4'h0);
        checks++;
        if (r_rd !== 32'h0000_0007) begin failures++; $display("FAIL abort_nowrite got=%h exp=00000007", r_rd); end
        // Abort a read in the middle of its wait states. prdata must clear.
        sel[1] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h30;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk); #1;
        checks++;
        if (rdata[1] !== 32'h30 || rdy[1] !== 1'b0) begin
            failures++; $display("FAIL ws2_wait_data got=%h rdy=%b exp 00000030/0", rdata[1], rdy[1]);
        end
        sel[1] = 1'b0; penable = 1'b0;
        @(negedge pclk); #1;
        checks++;
        if (rdata[1] !== 32'h0 || rdy[1] !== 1'b1) begin
            failures++; $display("FAIL ws2_abort got=%h rdy=%b exp 0/1", rdata[1], rdy[1]);
        end
    endtask

    task automatic test_idle_enable();
        sel[0] = 1'b1; penable = 1'b1; pwrite = 1'b1;
        paddr = 32'd3; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
        repeat (2) @(negedge pclk);
        #1;
        checks++;
        if (rdy[0] !== 1'b1 || rdata[0] !== 32'h0) begin
            failures++; $display("FAIL idle_enable_state got rdy=%b prdata=%h exp 1/0", rdy[0], rdata[0]);
        end
        sel[0] = 1'b0; penable = 1'b0;
        @(negedge pclk);
        xfer(0, 1'b0, 32'd3, 32'h0, 4'h0);
        checks++;
        if (r_rd !== 32'h0000_0003) begin failures++; $display("FAIL idle_enable_nowrite got=%h exp=00000003", r_rd); end
    endtask

    task automatic test_back_to_back();
        xfer(0, 1'b1, 32'd12, 32'h1111_2222, 4'hF);
        xfer(0, 1'b0, 32'd12, 32'h0, 4'h0);
        checks++;
        if (r_rd !== 32'h1111_2222 || r_waits !== 0) begin
            failures++; $display("FAIL b2b_read12 got=%h waits=%0d exp 11112222/0", r_rd, r_waits);
        end
        xfer(0, 1'b0, 32'd13, 32'h0, 4'h0);
        checks++;
        if (r_rd !== 32'h0000_000D) begin failures++; $display("FAIL b2b_read13 got=%h exp=0000000D", r_rd); end
    endtask

    task automatic test_reset_mid();
        sel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'd9; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk); #1;
        checks++;
        if (rdy[2] !== 1'b0) begin failures++; $display("FAIL ws3_in_wait got rdy=%b exp=0", rdy[2]); end
        prst = 1'b0;
        #1;
        checks++;
        if (rdy[2] !== 1'b1 || rdata[2] !== 32'h0 || slverr[2] !== 1'b0) begin
            failures++; $display("FAIL mid_reset got rdy=%b prdata=%h err=%b exp 1/0/0", rdy[2], rdata[2], slverr[2]);
        end
        @(negedge pclk);
        sel[2] = 1'b0; penable = 1'b0;
        @(negedge pclk);
        prst = 1'b1;
        xfer(2, 1'b0, 32'd9, 32'h0, 4'h0);
        checks++;
        if (r_rd !== 32'h0000_0009 || r_waits !== 3) begin
            failures++; $display("FAIL ws3_reset_read got=%h waits=%0d exp 00000009/3", r_rd, r_waits);
        end
        xfer(0, 1'b0, 32'd5, 32'h0, 4'h0);
        checks++;
        if (r_rd !== 32'h0000_0005) begin failures++; $display("FAIL mem_reinit got=%h exp=00000005", r_rd); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        prst = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0; pstrb = 4'h0;
        for (int i = 0; i < 3; i++) sel[i] = 1'b0;
        repeat (3) @(negedge pclk);
        #1;
        test_reset();
        @(negedge pclk);
        prst = 1'b1;
        test_read_default();
        test_strobe_write();
        test_wait_states();
        test_out_of_range();
        test_abort();
        test_idle_enable();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
